// File: rtl/id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register of the 5-stage MIPS32 core. Captures the decoded
// control vector, register operands, immediate and register addresses from
// the ID stage and presents them to EX and to the forwarding/hazard logic.
// A load-use stall from the hazard unit or a branch flush injects a bubble.
// Hold freezes the whole stage. A saturating counter records how many
// bubbles have been inserted, for performance debugging.
//
// Ports
//   clk, rst_n              rising-edge clock, synchronous active-low reset
//   Valid_ID                ID holds a real instruction
//   Ctrl_ID                 {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,
//                            RegDst,ALUOp[2:0]}
//   Read_Data1_ID/2_ID      register file read data (Rs / Rt)
//   Imm_ID                  sign-extended immediate
//   IF_ID_Reg_Rs/Rt/Rd      register fields of the instruction in ID
//   IF_ID_Pipeline_Enable   0 = load-use stall, write a bubble
//   Flush                   kill the ID instruction, write a bubble
//   Hold                    keep every register unchanged
//   Cnt_Clear               zero Bubble_Count
//   ID_EX_*                 registered copies of the ID values
//   ID_EX_Reg_Dst           write destination, RegDst ? Rd : Rt
//   Bubble_Count            bubbles + flushes since reset or clear
// ----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Valid_ID,
    input  logic [CTRL_W-1:0] Ctrl_ID,
    input  logic [DATA_W-1:0] Read_Data1_ID,
    input  logic [DATA_W-1:0] Read_Data2_ID,
    input  logic [DATA_W-1:0] Imm_ID,
    input  logic [RA_W-1:0]   IF_ID_Reg_Rs,
    input  logic [RA_W-1:0]   IF_ID_Reg_Rt,
    input  logic [RA_W-1:0]   IF_ID_Reg_Rd,
    input  logic              IF_ID_Pipeline_Enable,
    input  logic              Flush,
    input  logic              Hold,
    input  logic              Cnt_Clear,
    output logic              ID_EX_Valid,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemtoReg,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic [DATA_W-1:0] ID_EX_Read_Data1,
    output logic [DATA_W-1:0] ID_EX_Read_Data2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [RA_W-1:0]   ID_EX_Reg_Rs,
    output logic [RA_W-1:0]   ID_EX_Reg_Rt,
    output logic [RA_W-1:0]   ID_EX_Reg_Rd,
    output logic [RA_W-1:0]   ID_EX_Reg_Dst,
    output logic [CNT_W-1:0]  Bubble_Count
);

    localparam int REGDST_BIT = 3;

    logic write_bubble;
    logic load_en;

    // Flush beats Hold; a stall only acts when the stage is not held.
    assign write_bubble = Flush || (!Hold && !IF_ID_Pipeline_Enable);
    assign load_en      = !Flush && !Hold && IF_ID_Pipeline_Enable;

    // A bubble zeroes the register addresses too, so the forwarding unit
    // can never match against it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ID_EX_Valid      <= 1'b0;
            ID_EX_Ctrl       <= '0;
            ID_EX_Read_Data1 <= '0;
            ID_EX_Read_Data2 <= '0;
            ID_EX_Imm        <= '0;
            ID_EX_Reg_Rs     <= '0;
            ID_EX_Reg_Rt     <= '0;
            ID_EX_Reg_Rd     <= '0;
            ID_EX_Reg_Dst    <= '0;
        end else if (write_bubble) begin
            ID_EX_Valid      <= 1'b0;
            ID_EX_Ctrl       <= '0;
            ID_EX_Read_Data1 <= '0;
            ID_EX_Read_Data2 <= '0;
            ID_EX_Imm        <= '0;
            ID_EX_Reg_Rs     <= '0;
            ID_EX_Reg_Rt     <= '0;
            ID_EX_Reg_Rd     <= '0;
            ID_EX_Reg_Dst    <= '0;
        end else if (load_en) begin
            ID_EX_Valid      <= Valid_ID;
            ID_EX_Ctrl       <= Valid_ID ? Ctrl_ID : '0;
            ID_EX_Read_Data1 <= Read_Data1_ID;
            ID_EX_Read_Data2 <= Read_Data2_ID;
            ID_EX_Imm        <= Imm_ID;
            ID_EX_Reg_Rs     <= IF_ID_Reg_Rs;
            ID_EX_Reg_Rt     <= IF_ID_Reg_Rt;
            ID_EX_Reg_Rd     <= IF_ID_Reg_Rd;
            ID_EX_Reg_Dst    <= Ctrl_ID[REGDST_BIT] ? IF_ID_Reg_Rd : IF_ID_Reg_Rt;
        end
    end

    // Clear wins over an increment in the same cycle; the count saturates
    // at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Bubble_Count <= '0;
        end else if (Cnt_Clear) begin
            Bubble_Count <= '0;
        end else if (write_bubble && (Bubble_Count != {CNT_W{1'b1}})) begin
            Bubble_Count <= Bubble_Count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ID_EX_RegWrite = ID_EX_Ctrl[8];
    assign ID_EX_MemtoReg = ID_EX_Ctrl[7];
    assign ID_EX_MemRead  = ID_EX_Ctrl[6];
    assign ID_EX_MemWrite = ID_EX_Ctrl[5];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Self-checking bench for id_ex_stage_reg. A behavioural model of the stage
// contents is advanced on every rising edge from the inputs the bench drove,
// and each scenario task compares DUT outputs against it or against
// hand-derived constants.
// ----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Valid_ID;
    logic [8:0]  Ctrl_ID;
    logic [31:0] Read_Data1_ID, Read_Data2_ID, Imm_ID;
    logic [4:0]  IF_ID_Reg_Rs, IF_ID_Reg_Rt, IF_ID_Reg_Rd;
    logic        IF_ID_Pipeline_Enable, Flush, Hold, Cnt_Clear;

    logic        ID_EX_Valid;
    logic [8:0]  ID_EX_Ctrl;
    logic        ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite;
    logic [31:0] ID_EX_Read_Data1, ID_EX_Read_Data2, ID_EX_Imm;
    logic [4:0]  ID_EX_Reg_Rs, ID_EX_Reg_Rt, ID_EX_Reg_Rd, ID_EX_Reg_Dst;
    logic [15:0] Bubble_Count;

    int n_checks = 0;
    int n_fail   = 0;

    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd, m_dst;
    int          m_cnt;

    logic [141:0] dut_snap;
    logic [141:0] exp_snap;

    assign dut_snap = {ID_EX_Valid, ID_EX_Ctrl, ID_EX_Read_Data1, ID_EX_Read_Data2,
                       ID_EX_Imm, ID_EX_Reg_Rs, ID_EX_Reg_Rt, ID_EX_Reg_Rd,
                       ID_EX_Reg_Dst, Bubble_Count};
    assign exp_snap = {m_valid, m_ctrl, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd,
                       m_dst, m_cnt[15:0]};

    id_ex_stage_reg dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .Valid_ID              (Valid_ID),
        .Ctrl_ID               (Ctrl_ID),
        .Read_Data1_ID         (Read_Data1_ID),
        .Read_Data2_ID         (Read_Data2_ID),
        .Imm_ID                (Imm_ID),
        .IF_ID_Reg_Rs          (IF_ID_Reg_Rs),
        .IF_ID_Reg_Rt          (IF_ID_Reg_Rt),
        .IF_ID_Reg_Rd          (IF_ID_Reg_Rd),
        .IF_ID_Pipeline_Enable (IF_ID_Pipeline_Enable),
        .Flush                 (Flush),
        .Hold                  (Hold),
        .Cnt_Clear             (Cnt_Clear),
        .ID_EX_Valid           (ID_EX_Valid),
        .ID_EX_Ctrl            (ID_EX_Ctrl),
        .ID_EX_RegWrite        (ID_EX_RegWrite),
        .ID_EX_MemtoReg        (ID_EX_MemtoReg),
        .ID_EX_MemRead         (ID_EX_MemRead),
        .ID_EX_MemWrite        (ID_EX_MemWrite),
        .ID_EX_Read_Data1      (ID_EX_Read_Data1),
        .ID_EX_Read_Data2      (ID_EX_Read_Data2),
        .ID_EX_Imm             (ID_EX_Imm),
        .ID_EX_Reg_Rs          (ID_EX_Reg_Rs),
        .ID_EX_Reg_Rt          (ID_EX_Reg_Rt),
        .ID_EX_Reg_Rd          (ID_EX_Reg_Rd),
        .ID_EX_Reg_Dst         (ID_EX_Reg_Dst),
        .Bubble_Count          (Bubble_Count)
    );

    always #5 clk = ~clk;

    // Reference model: what the stage should hold after this edge, decided
    // from the priority rules reset > flush > hold > stall > load.
    task automatic model_update();
        bit bubble;
        if (!rst_n) begin
            {m_valid, m_ctrl, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd, m_dst} = '0;
            m_cnt = 0;
        end else begin
            bubble = Flush || (!Hold && !IF_ID_Pipeline_Enable);
            if (bubble) begin
                {m_valid, m_ctrl, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd, m_dst} = '0;
            end else if (!Hold) begin
                m_valid = Valid_ID;
                m_ctrl  = Valid_ID ? Ctrl_ID : 9'd0;
                m_d1    = Read_Data1_ID;
                m_d2    = Read_Data2_ID;
                m_imm   = Imm_ID;
                m_rs    = IF_ID_Reg_Rs;
                m_rt    = IF_ID_Reg_Rt;
                m_rd    = IF_ID_Reg_Rd;
                m_dst   = Ctrl_ID[3] ? IF_ID_Reg_Rd : IF_ID_Reg_Rt;
            end
            if (Cnt_Clear)
                m_cnt = 0;
            else if (bubble && m_cnt < 65535)
                m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_idle();
        rst_n = 1'b1;
        Valid_ID = 1'b0;
        Ctrl_ID = 9'd0;
        Read_Data1_ID = 32'd0;
        Read_Data2_ID = 32'd0;
        Imm_ID = 32'd0;
        IF_ID_Reg_Rs = 5'd0;
        IF_ID_Reg_Rt = 5'd0;
        IF_ID_Reg_Rd = 5'd0;
        IF_ID_Pipeline_Enable = 1'b1;
        Flush = 1'b0;
        Hold = 1'b0;
        Cnt_Clear = 1'b0;
    endtask

    task automatic drive_instr(input logic [8:0] ctrl, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd);
        Valid_ID = 1'b1;
        Ctrl_ID = ctrl;
        Read_Data1_ID = $urandom;
        Read_Data2_ID = $urandom;
        Imm_ID = $urandom;
        IF_ID_Reg_Rs = rs;
        IF_ID_Reg_Rt = rt;
        IF_ID_Reg_Rd = rd;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        Valid_ID = 1'b1;
        Ctrl_ID = 9'h1FF;
        Imm_ID = 32'hDEADBEEF;
        tick();
        tick();
        n_checks++;
        if (dut_snap !== 142'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %h expected 0", dut_snap);
        end
        n_checks++;
        if ({ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_named_ctrl: got %b expected 0000",
                     {ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        drive_idle();
        drive_instr(9'b101011010, 5'd3, 5'd4, 5'd5);
        tick();
        n_checks++;
        if ({ID_EX_Reg_Dst, ID_EX_RegWrite, ID_EX_Valid, ID_EX_Reg_Rs} !== {5'd5, 1'b1, 1'b1, 5'd3}) begin
            n_fail++;
            $display("[TB] FAIL load_regdst1: dst=%0d rw=%b v=%b rs=%0d expected dst=5 rw=1 v=1 rs=3",
                     ID_EX_Reg_Dst, ID_EX_RegWrite, ID_EX_Valid, ID_EX_Reg_Rs);
        end
        n_checks++;
        if (dut_snap !== exp_snap) begin
            n_fail++;
            $display("[TB] FAIL load_full: got %h expected %h", dut_snap, exp_snap);
        end
        drive_instr(9'b101010010, 5'd3, 5'd4, 5'd5);
        tick();
        n_checks++;
        if (ID_EX_Reg_Dst !== 5'd4) begin
            n_fail++;
            $display("[TB] FAIL load_regdst0: got %0d expected 4", ID_EX_Reg_Dst);
        end
        n_checks++;
        if ({ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite} !== 4'b1010) begin
            n_fail++;
            $display("[TB] FAIL load_named_ctrl: got %b expected 1010",
                     {ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite});
        end
        Valid_ID = 1'b0;
        tick();
        n_checks++;
        if ({ID_EX_Valid, ID_EX_Ctrl} !== 10'd0 || dut_snap !== exp_snap) begin
            n_fail++;
            $display("[TB] FAIL load_invalid: got %h expected %h", dut_snap, exp_snap);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] held_d1;
        drive_idle();
        drive_instr(9'b110100011, 5'd7, 5'd9, 5'd11);
        held_d1 = Read_Data1_ID;
        IF_ID_Pipeline_Enable = 1'b0;
        tick();
        n_checks++;
        if ({ID_EX_Valid, ID_EX_Ctrl, ID_EX_Reg_Rs, ID_EX_Reg_Rt, Bubble_Count} !==
            {1'b0, 9'd0, 5'd0, 5'd0, 16'd1}) begin
            n_fail++;
            $display("[TB] FAIL stall_bubble: v=%b ctrl=%h rs=%0d rt=%0d cnt=%0d expected 0 0 0 0 1",
                     ID_EX_Valid, ID_EX_Ctrl, ID_EX_Reg_Rs, ID_EX_Reg_Rt, Bubble_Count);
        end
        IF_ID_Pipeline_Enable = 1'b1;
        tick();
        n_checks++;
        if ({ID_EX_Valid, ID_EX_Ctrl, ID_EX_Reg_Rs, ID_EX_Read_Data1, Bubble_Count} !==
            {1'b1, 9'b110100011, 5'd7, held_d1, 16'd1}) begin
            n_fail++;
            $display("[TB] FAIL stall_release: got v=%b ctrl=%h rs=%0d d1=%h cnt=%0d expected 1 %h 7 %h 1",
                     ID_EX_Valid, ID_EX_Ctrl, ID_EX_Reg_Rs, ID_EX_Read_Data1, Bubble_Count,
                     9'b110100011, held_d1);
        end
    endtask

    task automatic test_flush_hold();
        logic [141:0] frozen;
        drive_idle();
        drive_instr(9'b111111111, 5'd1, 5'd2, 5'd3);
        Flush = 1'b1;
        Hold = 1'b1;
        tick();
        n_checks++;
        if ({ID_EX_Valid, ID_EX_Ctrl, ID_EX_Reg_Dst, Bubble_Count} !== {1'b0, 9'd0, 5'd0, 16'd2}) begin
            n_fail++;
            $display("[TB] FAIL flush_over_hold: v=%b ctrl=%h dst=%0d cnt=%0d expected 0 0 0 2",
                     ID_EX_Valid, ID_EX_Ctrl, ID_EX_Reg_Dst, Bubble_Count);
        end
        Flush = 1'b0;
        Hold = 1'b0;
        tick();
        frozen = exp_snap;
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_instr(9'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            IF_ID_Pipeline_Enable = i[0];
            tick();
            n_checks++;
            if (dut_snap !== frozen) begin
                n_fail++;
                $display("[TB] FAIL hold_frozen[%0d]: got %h expected %h", i, dut_snap, frozen);
            end
        end
        Hold = 1'b0;
        IF_ID_Pipeline_Enable = 1'b1;
    endtask

    task automatic test_saturation();
        drive_idle();
        Cnt_Clear = 1'b1;
        tick();
        Cnt_Clear = 1'b0;
        IF_ID_Pipeline_Enable = 1'b0;
        for (int i = 0; i < 65534; i++) tick();
        n_checks++;
        if (Bubble_Count !== 16'hFFFE) begin
            n_fail++;
            $display("[TB] FAIL count_fffe: got %h expected fffe", Bubble_Count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (Bubble_Count !== 16'hFFFF) begin
                n_fail++;
                $display("[TB] FAIL count_saturate[%0d]: got %h expected ffff", i, Bubble_Count);
            end
        end
        Cnt_Clear = 1'b1;
        tick();
        n_checks++;
        if (Bubble_Count !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL count_clear_with_stall: got %h expected 0000", Bubble_Count);
        end
        Hold = 1'b1;
        IF_ID_Pipeline_Enable = 1'b1;
        Cnt_Clear = 1'b0;
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        Cnt_Clear = 1'b1;
        tick();
        n_checks++;
        if (Bubble_Count !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL count_clear_under_hold: got %h expected 0000", Bubble_Count);
        end
        drive_idle();
    endtask

    task automatic test_hold_reset();
        drive_idle();
        drive_instr(9'b101011010, 5'd12, 5'd13, 5'd14);
        tick();
        Hold = 1'b1;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (dut_snap !== 142'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_during_hold: got %h expected 0", dut_snap);
        end
        drive_idle();
    endtask

    task automatic test_random();
        drive_idle();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            Valid_ID = ($urandom_range(0, 3) != 0);
            Ctrl_ID = 9'($urandom);
            Read_Data1_ID = $urandom;
            Read_Data2_ID = $urandom;
            Imm_ID = $urandom;
            IF_ID_Reg_Rs = 5'($urandom);
            IF_ID_Reg_Rt = 5'($urandom);
            IF_ID_Reg_Rd = 5'($urandom);
            IF_ID_Pipeline_Enable = ($urandom_range(0, 4) != 0);
            Flush = ($urandom_range(0, 7) == 0);
            Hold = ($urandom_range(0, 5) == 0);
            Cnt_Clear = ($urandom_range(0, 29) == 0);
            tick();
            n_checks++;
            if (dut_snap !== exp_snap ||
                {ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite} !== m_ctrl[8:5]) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: got %h named %b expected %h named %b", i,
                         dut_snap, {ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite},
                         exp_snap, m_ctrl[8:5]);
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        {m_valid, m_ctrl, m_d1, m_d2, m_imm, m_rs, m_rt, m_rd, m_dst} = '0;
        m_cnt = 0;
        test_reset();
        test_load();
        test_load_use();
        test_flush_hold();
        test_hold_reset();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
